// File: rtl/uart_tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_pkg
//   Shared definitions for the UART transmit arbiter: FSM state encoding,
//   the fixed grant_id width, the index of each known requester and a small
//   modulo-increment helper used for the round-robin pointer.
// -----------------------------------------------------------------------------
package uart_tx_arbiter_pkg;

    // grant_id is always presented on 3 bits regardless of NUM_REQ.
    localparam int ID_W = 3;

    // Requester slots as wired in top.
    localparam int REQ_BANNER = 0;
    localparam int REQ_ECHO   = 1;
    localparam int REQ_RESULT = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,  // no lock held, arbitrating
        LOAD      = 2'd1,  // lock held, waiting for the owner's next byte
        WAIT_ACK  = 2'd2,  // SEND raised, waiting for READY to fall
        WAIT_DONE = 2'd3   // frame in flight, waiting for READY to rise
    } state_e;

    // (idx + 1) mod n, for idx already in [0, n-1].
    function automatic int wrap_inc(input int idx, input int n);
        if (idx + 1 >= n) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin selector. Searches req_i starting at rr_ptr_i,
//   then rr_ptr_i+1, ... wrapping modulo NUM_REQ, and reports the first set
//   bit.
//
// Ports
//   req_i     in  NUM_REQ  request vector
//   rr_ptr_i  in  IDX_W    highest-priority index this cycle (< NUM_REQ)
//   any_o     out 1        at least one request is set
//   idx_o     out IDX_W    selected index (0 when any_o is low)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic               any_o,
    output logic [IDX_W-1:0]   idx_o
);

    int               sum;
    logic [IDX_W-1:0] pos;
    logic             found;
    logic [IDX_W-1:0] found_idx;

    always_comb begin
        // NOTE: every variable driven here gets a default before any branch,
        // so no path can leave one unassigned and infer a latch.
        sum       = 0;
        pos       = '0;
        found     = 1'b0;
        found_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // rr_ptr_i is always < NUM_REQ, so one subtraction wraps the sum.
            sum = int'(rr_ptr_i) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            pos = IDX_W'(sum);
            if (!found && req_i[pos]) begin
                found     = 1'b1;
                found_idx = pos;
            end
        end
        any_o = found;
        idx_o = found_idx;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART transmitter (UART_TX_CTRL SEND/DATA/READY) among NUM_REQ
//   byte-stream requesters. A requester keeps the lock from its first byte up
//   to the byte flagged last, so messages never interleave. Messages are
//   granted round-robin. Two watchdogs recover from a transmitter that never
//   acknowledges SEND (err_ack) and from an owner that stops supplying bytes
//   in the middle of a message (err_gap).
//
// Ports
//   CLK          in  1          system clock
//   rst          in  1          synchronous active-high reset
//   req_valid    in  NUM_REQ    requester i has a byte
//   req_data     in  8*NUM_REQ  byte of requester i at [8i+7:8i]
//   req_last     in  NUM_REQ    byte is the final byte of its message
//   req_ready    out NUM_REQ    byte taken when req_valid[i] & req_ready[i]
//   tx_send      out 1          SEND to UART_TX_CTRL
//   tx_data      out 8          DATA to UART_TX_CTRL
//   tx_ready     in  1          READY from UART_TX_CTRL
//   grant_valid  out 1          a message lock is held
//   grant_id     out 3          current owner index, upper bits zero
//   err_ack      out 1          one-cycle pulse: READY never fell after SEND
//   err_gap      out 1          one-cycle pulse: owner idle too long, lock dropped
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int ACK_TIMEOUT = 16,
    parameter int GAP_TIMEOUT = 100000
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_send,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic                 grant_valid,
    output logic [ID_W-1:0]      grant_id,
    output logic                 err_ack,
    output logic                 err_gap
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);

    // Counter values at which the watchdog fires on the current cycle.
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e           state_q,       state_d;
    logic [IDX_W-1:0] owner_q,       owner_d;
    logic [IDX_W-1:0] rr_ptr_q,      rr_ptr_d;
    logic             grant_valid_q, grant_valid_d;
    logic             tx_send_q,     tx_send_d;
    logic [7:0]       tx_data_q,     tx_data_d;
    logic             last_q,        last_d;
    logic             err_ack_q,     err_ack_d;
    logic             err_gap_q,     err_gap_d;
    logic [ACK_W-1:0] ack_cnt_q,     ack_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q,     gap_cnt_d;

    // ------------------------------------------------------------------------
    // Round-robin selection among waiting requesters
    // ------------------------------------------------------------------------
    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i    (req_valid),
        .rr_ptr_i (rr_ptr_q),
        .any_o    (pick_any),
        .idx_o    (pick_idx)
    );

    // Byte-lane view of the flat data bus.
    logic [NUM_REQ-1:0][7:0] req_bytes;
    assign req_bytes = req_data;

    // The owner's byte is taken only while the transmitter is free, so one
    // accepted transfer always maps to exactly one SEND.
    logic owner_ready;
    logic accept;
    assign owner_ready = (state_q == LOAD) && tx_ready;
    assign accept      = owner_ready && req_valid[owner_q];

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = owner_ready && (owner_q == IDX_W'(i));
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        grant_valid_d = grant_valid_q;
        tx_send_d     = tx_send_q;
        tx_data_d     = tx_data_q;
        last_d        = last_q;
        ack_cnt_d     = ack_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        err_ack_d     = 1'b0;
        err_gap_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    owner_d       = pick_idx;
                    grant_valid_d = 1'b1;
                    gap_cnt_d     = '0;
                    state_d       = LOAD;
                end
            end

            LOAD: begin
                if (accept) begin
                    tx_data_d = req_bytes[owner_q];
                    tx_send_d = 1'b1;
                    last_d    = req_last[owner_q];
                    gap_cnt_d = '0;
                    ack_cnt_d = '0;
                    state_d   = WAIT_ACK;
                end else if (gap_cnt_q == GAP_LAST) begin
                    // Owner stalled mid-message: drop the lock. rr_ptr is left
                    // alone; the stalled owner only wins again if it re-asserts.
                    err_gap_d     = 1'b1;
                    grant_valid_d = 1'b0;
                    gap_cnt_d     = '0;
                    state_d       = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            WAIT_ACK: begin
                // SEND stays high until the transmitter shows it has latched
                // the byte by dropping READY.
                if (!tx_ready) begin
                    tx_send_d = 1'b0;
                    state_d   = WAIT_DONE;
                end else if (ack_cnt_q == ACK_LAST) begin
                    tx_send_d = 1'b0;
                    err_ack_d = 1'b1;
                    state_d   = WAIT_DONE;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end

            WAIT_DONE: begin
                if (tx_ready) begin
                    if (last_q) begin
                        grant_valid_d = 1'b0;
                        rr_ptr_d      = IDX_W'(wrap_inc(int'(owner_q), NUM_REQ));
                        state_d       = IDLE;
                    end else begin
                        gap_cnt_d = '0;
                        state_d   = LOAD;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge value of every other, independent of statement order.
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            grant_valid_q <= 1'b0;
            tx_send_q     <= 1'b0;
            tx_data_q     <= 8'h00;
            last_q        <= 1'b0;
            err_ack_q     <= 1'b0;
            err_gap_q     <= 1'b0;
            ack_cnt_q     <= '0;
            gap_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_valid_q <= grant_valid_d;
            tx_send_q     <= tx_send_d;
            tx_data_q     <= tx_data_d;
            last_q        <= last_d;
            err_ack_q     <= err_ack_d;
            err_gap_q     <= err_gap_d;
            ack_cnt_q     <= ack_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign tx_send     = tx_send_q;
    assign tx_data     = tx_data_q;
    assign grant_valid = grant_valid_q;
    // owner_q only changes on a grant, so it doubles as the grant_id register.
    assign grant_id    = ID_W'(owner_q);
    assign err_ack     = err_ack_q;
    assign err_gap     = err_gap_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter (UART_TX_CTRL: SEND/DATA/READY) among NUM_REQ byte-stream requesters, e.g. banner printer, key echo and result printer.
- Grants are message-level: a requester holds the UART from its first byte through the byte flagged last, so strings never interleave.
- Round-robin between messages; watchdogs recover from a stuck transmitter or a stalled owner.
- Sits between the mode/menu FSM in top and UART_TX_CTRL.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- ACK_TIMEOUT, 16, max cycles waiting for READY to fall after SEND
- GAP_TIMEOUT, 100000, max idle cycles between bytes of a locked message

Ports:
- CLK  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  requester i has a byte
- req_data  in  8*NUM_REQ  byte for requester i, bits [8i+7:8i]
- req_last  in  NUM_REQ  byte is the final byte of the message
- req_ready  out  NUM_REQ  byte accepted when req_valid[i] and req_ready[i] are both high
- tx_send  out  1  to UART_TX_CTRL SEND
- tx_data  out  8  to UART_TX_CTRL DATA
- tx_ready  in  1  from UART_TX_CTRL READY
- grant_valid  out  1  a message lock is held
- grant_id  out  3  current owner index
- err_ack  out  1  one-cycle pulse on ACK timeout
- err_gap  out  1  one-cycle pulse on GAP timeout

Behaviour:
- Reset values: tx_send=0, tx_data=0x00, grant_valid=0, grant_id=0, err_*=0, rr_ptr=0, state=IDLE. req_ready is all 0 because it is decoded from state.
- req_ready[i] is combinational: (state==LOAD) && (i==owner) && tx_ready. It is 0 for all non-owners at all times.
- IDLE:
  - If any req_valid is high, pick the first set bit searching rr_ptr, rr_ptr+1, … with wrap mod NUM_REQ.
  - Register owner, set grant_valid<=1 and grant_id<=owner, go to LOAD. Arbitration takes 1 cycle.
  - A request arriving in the same cycle is eligible.
- LOAD:
  - On an accepted transfer: tx_data<=req_data[owner], tx_send<=1, last_r<=req_last[owner], clear gap counter, go to WAIT_ACK.
  - Otherwise increment the gap counter. When it reaches GAP_TIMEOUT, pulse err_gap, release the lock, go to IDLE.
- WAIT_ACK:
  - tx_send is held high until tx_ready==0 is sampled; then tx_send<=0 and go to WAIT_DONE.
  - If ACK_TIMEOUT cycles elapse first: tx_send<=0, pulse err_ack, go to WAIT_DONE.
- WAIT_DONE:
  - Wait for tx_ready==1.
  - If last_r: go to IDLE, grant_valid<=0, rr_ptr<=(owner+1) mod NUM_REQ.
  - Otherwise go to LOAD.
- Byte rate: at most one byte per UART frame. A byte is never sent twice, and exactly one byte is issued per accepted transfer.
- The owner dropping req_valid mid-message keeps the lock until GAP_TIMEOUT expires.
- A byte with req_last=1 on the first transfer forms a 1-byte message.
- Other requesters' valid/data are ignored while the lock is held and must stay stable; no data is lost.
- Reset mid-operation: all outputs return to reset values on the next edge. A frame already inside UART_TX_CTRL completes on its own; the next LOAD waits for tx_ready.
- grant_id width is fixed at 3 bits. Unused upper bits are 0.

Decomposition:
- Shared package: state encoding constants (IDLE, LOAD, WAIT_ACK, WAIT_DONE) and requester index constants (REQ_BANNER=0, REQ_ECHO=1, REQ_RESULT=2), used by top when wiring.
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: req vector, rr_ptr.
  - Outputs: any, idx.
  - Kept separate so it can be unit-tested and reused.

Test Plan:
- Single message: req0 sends "Hi\n" (0x48, 0x69, 0x0A with last on 0x0A); UART model has READY low for 10 cycles per byte. Expect three tx_send episodes with tx_data 0x48, 0x69, 0x0A in order, exactly 3 handshakes on req_ready[0], then IDLE with grant_valid=0.
- Contention: req0 "AB" (last on B) and req1 "c" both valid at cycle 0. Expect output A, B, c with no interleave, grant_id 0 then 1, rr_ptr=2 afterwards.
- Fairness: all three requesters continuously valid with 1-byte messages 0x30+i. Expect grant order 0, 1, 2, 0, 1, 2 over six messages.
- ACK timeout: UART model holds READY high and ignores SEND. Expect err_ack pulse 16 cycles after tx_send rises, tx_send=0, and the FSM advances.
- Gap timeout (GAP_TIMEOUT=20 in sim): req0 sends "X" without last, then drops valid while req2 is valid. Expect err_gap at the 20th idle cycle, then grant to 2.
- Reset mid-frame: assert rst in WAIT_ACK. Expect tx_send=0, grant_valid=0, req_ready all 0 on the next edge, and normal operation afterwards.
